// File: rtl/evm_booth_arbiter.sv
// evm_booth_arbiter: round-robin arbiter sharing one EVM tally core between NUM_BOOTHS booths
// Ports: clk, rst (async active-low), session_open gates new grants; booth_req/booth_cand carry
// per-booth requests and 2-bit codes; voting_in_progress is core-ready; booth_ack/booth_reject
// pulse back to the granted booth; candidate_ready and vote_candidate_1..3 drive the core;
// grant_id, busy and votes_issued report status.
// Optional EVM_ARB_TIMEOUT_EN: reject the granted booth after TIMEOUT cycles stuck in WAIT.
module evm_booth_arbiter #(
  parameter int NUM_BOOTHS = 4,
  parameter int GAP_CYCLES = 2,
  parameter int TIMEOUT = 8,
  localparam int IW = $clog2(NUM_BOOTHS)
) (
  input logic clk,
  input logic rst,
  input logic session_open,
  input logic [NUM_BOOTHS-1:0] booth_req,
  input logic [2*NUM_BOOTHS-1:0] booth_cand,
  input logic voting_in_progress,
  output logic [NUM_BOOTHS-1:0] booth_ack,
  output logic [NUM_BOOTHS-1:0] booth_reject,
  output logic candidate_ready,
  output logic vote_candidate_1,
  output logic vote_candidate_2,
  output logic vote_candidate_3,
  output logic [IW-1:0] grant_id,
  output logic busy,
  output logic [15:0] votes_issued
);
  typedef enum logic [2:0] {IDLE, ARM, WAIT, CAST, GAP} state_t;
  // Outputs are registered one edge ahead, so the IDLE cycle that samples the next
  // request counts as the last gap cycle; GAP itself lasts GAP_CYCLES-1 cycles.
  localparam state_t AFTER = GAP_CYCLES > 1 ? GAP : IDLE;
  localparam logic AFTER_BUSY = GAP_CYCLES > 1;
  state_t state;
  logic [IW-1:0] last_grant, sel, idx;
  logic [1:0] code;
  logic [15:0] cnt;
`ifdef EVM_ARB_TIMEOUT_EN
  logic [15:0] wcnt;
`endif
  // Descending scan so the nearest requester after last_grant wins.
  always_comb begin
    sel = last_grant;
    idx = '0;
    for (int k = NUM_BOOTHS; k >= 1; k--) begin
      idx = IW'((int'(last_grant) + k) % NUM_BOOTHS);
      if (booth_req[idx]) sel = idx;
    end
  end
  wire [1:0] sel_code = booth_cand[{sel, 1'b0} +: 2];
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      booth_ack <= '0;
      booth_reject <= '0;
      candidate_ready <= 1'b0;
      vote_candidate_1 <= 1'b0;
      vote_candidate_2 <= 1'b0;
      vote_candidate_3 <= 1'b0;
      grant_id <= '0;
      busy <= 1'b0;
      votes_issued <= '0;
      last_grant <= IW'(NUM_BOOTHS - 1);
      code <= '0;
      cnt <= '0;
`ifdef EVM_ARB_TIMEOUT_EN
      wcnt <= '0;
`endif
    end else begin
      booth_ack <= '0;
      booth_reject <= '0;
      candidate_ready <= 1'b0;
      vote_candidate_1 <= 1'b0;
      vote_candidate_2 <= 1'b0;
      vote_candidate_3 <= 1'b0;
      case (state)
        IDLE: if (session_open && |booth_req) begin
          grant_id <= sel;
          last_grant <= sel;
          code <= sel_code;
          state <= ARM;
          busy <= 1'b1;
          // ARM-cycle pulses are registered here so they show in the ARM cycle itself.
          if (sel_code != 2'b00) candidate_ready <= 1'b1;
          else booth_reject[sel] <= 1'b1;
        end
        ARM: begin
          state <= code != 2'b00 ? WAIT : AFTER;
          busy <= code != 2'b00 || AFTER_BUSY;
          cnt <= '0;
`ifdef EVM_ARB_TIMEOUT_EN
          wcnt <= '0;
`endif
        end
        WAIT: begin
          if (voting_in_progress) begin
            state <= CAST;
            vote_candidate_1 <= code == 2'd1;
            vote_candidate_2 <= code == 2'd2;
            vote_candidate_3 <= code == 2'd3;
            booth_ack[grant_id] <= 1'b1;
            votes_issued <= votes_issued + {15'd0, votes_issued != 16'hFFFF};
          end
`ifdef EVM_ARB_TIMEOUT_EN
          else if (wcnt == 16'(TIMEOUT - 1)) begin
            state <= AFTER;
            busy <= AFTER_BUSY;
            booth_reject[grant_id] <= 1'b1;
            cnt <= '0;
          end else wcnt <= wcnt + 16'd1;
`endif
        end
        CAST: begin
          state <= AFTER;
          busy <= AFTER_BUSY;
          cnt <= '0;
        end
        GAP: if (cnt == 16'(GAP_CYCLES - 2)) begin
          state <= IDLE;
          busy <= 1'b0;
        end else cnt <= cnt + 16'd1;
        default: begin
          state <= IDLE;
          busy <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: doc/evm_booth_arbiter.md
# evm_booth_arbiter

- Shares one EVM tally core between `NUM_BOOTHS` voting booths.
- Each booth raises a level request carrying a 2-bit candidate code.
- The arbiter grants booths round-robin, sequences the core's `candidate_ready` / `vote_candidate_N` inputs for the granted booth, and returns an ack or reject pulse to that booth.
- It sits between the booth front-ends and the EVM core, on the core's input side.

## Interface

Parameters:

- `NUM_BOOTHS`, default 4: number of requesting booths (2–8).
- `GAP_CYCLES`, default 2: idle cycles inserted after every transaction (≥1).
- `TIMEOUT`, default 8: maximum cycles spent in WAIT (used only with `EVM_ARB_TIMEOUT_EN`).

Ports:

- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `session_open` in 1: when high, new grants are allowed.
- `booth_req` in `NUM_BOOTHS`: per-booth level request, held until that booth's ack or reject.
- `booth_cand` in `2*NUM_BOOTHS`: per-booth candidate code at bits [2i+1:2i]. Codes 01/10/11 select candidate 1/2/3; 00 is invalid.
- `voting_in_progress` in 1: core-ready indication from the EVM core.
- `booth_ack` out `NUM_BOOTHS`: one-cycle pulse when the booth's vote is cast.
- `booth_reject` out `NUM_BOOTHS`: one-cycle pulse when the booth's request is dropped.
- `candidate_ready` out 1: one-cycle arm pulse to the core.
- `vote_candidate_1`, `vote_candidate_2`, `vote_candidate_3` out 1 each: one-hot, one-cycle vote pulses to the core.
- `grant_id` out `$clog2(NUM_BOOTHS)`: index of the booth currently or last granted.
- `busy` out 1: high in every state except IDLE.
- `votes_issued` out 16: count of cast votes, saturates at 16'hFFFF.

## Operation

- FSM states: IDLE, ARM, WAIT, CAST, GAP. All outputs are registered.
- **IDLE**
  - If `session_open` and any `booth_req` bit is set: select the first requesting booth at or after `last_grant+1`, with wrap-around.
  - Latch its index into `grant_id` and its candidate code, set `last_grant` to that index, go to ARM.
  - `booth_req` is sampled only in IDLE.
- **ARM**
  - Valid code: `candidate_ready`=1 for this cycle, then go to WAIT.
  - Code 00: `candidate_ready` stays 0; pulse `booth_reject[grant_id]`, then go to GAP.
- **WAIT**
  - Stay until `voting_in_progress` is sampled high, then go to CAST.
- **CAST**
  - Assert exactly one `vote_candidate_N` matching the latched code, plus `booth_ack[grant_id]`, for one cycle.
  - Increment `votes_issued` unless it is at 16'hFFFF.
  - Go to GAP.
- **GAP**
  - Count `GAP_CYCLES` cycles, then return to IDLE.
  - Ensures the acked booth has dropped `booth_req` before the next sample.
- **Reset state:** IDLE; all outputs 0; `grant_id`=0; `votes_issued`=0; `last_grant`=`NUM_BOOTHS-1`, so booth 0 has first priority.
- **Boundary conditions**
  - `session_open` falling mid-transaction: the current transaction completes; only new grants are blocked.
  - Simultaneous requests: strict round-robin. A booth just served is last in priority on the next grant.
  - Candidate code changing after grant: ignored; the code latched in IDLE is used.
  - `rst` asserted mid-transaction: immediate return to reset state. No partial pulse completes.
  - `votes_issued` at 16'hFFFF stays there; votes are still cast and acked.

## Timing

- Edge E0 samples a request in IDLE.
- `candidate_ready` is high in the cycle after E0.
- If `voting_in_progress` is already high, the vote pulse and `booth_ack` appear in the cycle after E2.
  - Minimum request-to-vote latency: 3 cycles.
- Each extra cycle of `voting_in_progress` low adds one WAIT cycle.
- The next grant is sampled no earlier than E3 + `GAP_CYCLES`.
  - Minimum transaction spacing: 3 + `GAP_CYCLES` cycles.
- `booth_ack`, `booth_reject`, `candidate_ready` and `vote_candidate_N` are never high for more than one consecutive cycle.
- `booth_ack` and `booth_reject` are never both high for the same booth.

## Configuration

- **Macro:** `EVM_ARB_TIMEOUT_EN`.
- **Defined:** WAIT counts cycles.
  - If `voting_in_progress` has not been sampled high after `TIMEOUT` cycles in WAIT: pulse `booth_reject[grant_id]`, go to GAP, no vote is cast.
- **Undefined:** WAIT holds indefinitely; no timeout counter is present.

## Test plan

- **Reset:** `rst`=0 mid-CAST → all outputs 0 on the same cycle, `votes_issued`=0, `busy`=0; after release, booth 0 is served first.
- **Single vote:** booth 2 requests with code 10, `voting_in_progress`=1 → `candidate_ready` at E0+1, `vote_candidate_2` and `booth_ack`=4'b0100 at E0+3, `votes_issued`=1.
- **Round-robin:** all 4 booths request continuously with valid codes → grant order 0,1,2,3,0, and each `booth_ack` is spaced 3+`GAP_CYCLES`=5 cycles apart.
- **Invalid code:** booth 1 requests with code 00 → `booth_reject`=4'b0010 at E0+1, no `candidate_ready`, no vote pulse, `votes_issued` unchanged.
- **Timeout (`EVM_ARB_TIMEOUT_EN`):** `voting_in_progress` held 0 → `booth_reject` after 8 WAIT cycles and no vote. With the macro undefined, the arbiter stays in WAIT until `voting_in_progress` rises, then votes.
- **Session gating:** `session_open`=0 with requests pending → no grant, `busy`=0. Drop `session_open` during WAIT → the transaction still completes with an ack.
